// File: rtl/zbb_pkg.sv
// -----------------------------------------------------------------------------
// zbb_pkg -- shared definitions for the Zbb bit-count controller.
//
// Contents:
//   ZBB_CNT_CLZ / ZBB_CNT_CTZ / ZBB_CNT_CPOP / ZBB_CNT_RSV : op encodings
//   state_t  : controller FSM state (IDLE, RUN, DONE)
//   NIBBLES  : nibbles examined per operation (32-bit operand)
//   CNT_W    : accumulator width; holds 0..32
//   LAST_NIB : nibble counter value of the final RUN cycle
// -----------------------------------------------------------------------------
package zbb_pkg;

    localparam logic [1:0] ZBB_CNT_CLZ  = 2'b00;
    localparam logic [1:0] ZBB_CNT_CTZ  = 2'b01;
    localparam logic [1:0] ZBB_CNT_CPOP = 2'b10;
    localparam logic [1:0] ZBB_CNT_RSV  = 2'b11;

    localparam int NIBBLES = 8;
    localparam int CNT_W   = 6;

    localparam logic [2:0] LAST_NIB = 3'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/zbb_count_ctrl_if.sv
// -----------------------------------------------------------------------------
// zbb_count_ctrl_if -- request/response bundle between the CPU and the
// Zbb bit-count controller.
//
// Handshake: a request is accepted on a rising clock edge where start=1 and
// busy=0; op and operand are captured on that same edge. start is ignored
// while busy=1 (no queueing). done is a single-cycle pulse marking result as
// valid; result then holds until the next accepted request completes.
//
// Signals:
//   start   : request (master -> slave)
//   op      : 00=clz, 01=ctz, 10=cpop, 11=reserved (master -> slave)
//   operand : 32-bit source value (master -> slave)
//   busy    : high while counting; CPU stall qualifier (slave -> master)
//   done    : one-cycle result-valid pulse (slave -> master)
//   result  : count, zero-extended to 32 bits (slave -> master)
// -----------------------------------------------------------------------------
interface zbb_count_ctrl_if;

    logic        start;
    logic [1:0]  op;
    logic [31:0] operand;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, operand,
        input  busy, done, result
    );

    modport slave (
        input  start, op, operand,
        output busy, done, result
    );

endinterface

// File: rtl/zbb_nibble_cnt.sv
// -----------------------------------------------------------------------------
// zbb_nibble_cnt -- combinational counts for one 4-bit nibble.
//
// Ports:
//   nib : input nibble
//   lz  : leading zeros counted from bit 3 (0..4)
//   tz  : trailing zeros counted from bit 0 (0..4)
//   pop : number of set bits (0..4)
// -----------------------------------------------------------------------------
module zbb_nibble_cnt (
    input  logic [3:0] nib,
    output logic [2:0] lz,
    output logic [2:0] tz,
    output logic [2:0] pop
);

    always_comb begin
        // Scan upward: the highest set bit is written last and decides lz.
        lz = 3'd4;
        for (int i = 0; i < 4; i++) begin
            if (nib[i]) lz = 3'(3 - i);
        end
        // Scan downward: the lowest set bit is written last and decides tz.
        tz = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (nib[i]) tz = 3'(i);
        end
        pop = {2'b00, nib[0]} + {2'b00, nib[1]} + {2'b00, nib[2]} + {2'b00, nib[3]};
    end

endmodule

// File: rtl/zbb_count_ctrl.sv
// -----------------------------------------------------------------------------
// zbb_count_ctrl -- iterative clz / ctz / cpop unit, one nibble per cycle.
//
// Ports:
//   clk       : sole clock, rising edge
//   rst       : synchronous, active-high reset
//   bus       : zbb_count_ctrl_if.slave (start/op/operand in, busy/done/result out)
//   dbg_state : current FSM state
//
// Operation: an accepted request loads the operand into a shift register and
// spends eight RUN cycles walking it a nibble at a time (clz from the MSB
// end, ctz/cpop from the LSB end), then one DONE cycle pulses done. op=11
// skips RUN and reports 0 in the next cycle. A request seen in DONE is
// accepted directly, so back-to-back operations need no IDLE cycle.
//
// Configuration macro: ZBB_COUNT_EARLY_EXIT_EN
//   defined   : clz/ctz leave RUN in the cycle the first nonzero nibble is met
//   undefined : every counting op takes eight RUN cycles
// -----------------------------------------------------------------------------
module zbb_count_ctrl
    import zbb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    zbb_count_ctrl_if.slave   bus,
    output state_t            dbg_state
);

    state_t             state_q, state_d;
    logic [31:0]        sr_q, sr_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               found_q, found_d;
    logic [1:0]         op_q, op_d;
    logic [CNT_W-1:0]   res_q, res_d;

    logic [3:0]         nibble;
    logic [2:0]         nib_lz, nib_tz, nib_pop;
    logic               last;

    // clz consumes from the top of the shift register, ctz/cpop from the bottom.
    assign nibble = (op_q == ZBB_CNT_CLZ) ? sr_q[31:28] : sr_q[3:0];

    zbb_nibble_cnt u_nibble_cnt (
        .nib (nibble),
        .lz  (nib_lz),
        .tz  (nib_tz),
        .pop (nib_pop)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            op_q    <= ZBB_CNT_CLZ;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        found_d = found_q;
        op_d    = op_q;
        res_d   = res_q;
        last    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    if (bus.op == ZBB_CNT_RSV) begin
                        state_d = ST_DONE;
                        res_d   = '0;
                    end else begin
                        state_d = ST_RUN;
                        sr_d    = bus.operand;
                        acc_d   = '0;
                        cnt_d   = '0;
                        found_d = 1'b0;
                        op_d    = bus.op;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                sr_d  = (op_q == ZBB_CNT_CLZ) ? {sr_q[27:0], 4'b0000} : {4'b0000, sr_q[31:4]};
                cnt_d = cnt_q + 3'd1;

                if (op_q == ZBB_CNT_CPOP) begin
                    acc_d = acc_q + CNT_W'(nib_pop);
                end else if (!found_q) begin
                    // Whole zero nibbles add 4; the first nonzero one adds its
                    // partial count and freezes the accumulator from then on.
                    if (nibble == 4'h0) begin
                        acc_d = acc_q + CNT_W'(4);
                    end else begin
                        acc_d   = acc_q + CNT_W'((op_q == ZBB_CNT_CLZ) ? nib_lz : nib_tz);
                        found_d = 1'b1;
                    end
                end

                last = (cnt_q == LAST_NIB);
`ifdef ZBB_COUNT_EARLY_EXIT_EN
                if ((op_q != ZBB_CNT_CPOP) && !found_q && (nibble != 4'h0)) begin
                    last = 1'b1;
                end
`endif
                // result only moves on the RUN->DONE transition.
                if (last) begin
                    state_d = ST_DONE;
                    res_d   = acc_d;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy   = (state_q == ST_RUN);
        bus.done   = (state_q == ST_DONE);
        bus.result = {{(32 - CNT_W){1'b0}}, res_q};
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_zbb_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_zbb_count_ctrl -- self-checking bench for zbb_count_ctrl.
// Honours ZBB_COUNT_EARLY_EXIT_EN for expected latencies.
// -----------------------------------------------------------------------------
module tb_zbb_count_ctrl;
    import zbb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    zbb_count_ctrl_if bus ();
    state_t dbg_state;

    zbb_count_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] operand;
        logic [31:0] res;
        int          lat_fixed;
        int          lat_ee;
    } vec_t;

    vec_t tbl[12];

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_count(input logic [1:0] op, input logic [31:0] v);
        int n = 0;
        bit stop = 0;
        case (op)
            2'b00: for (int i = 31; i >= 0; i--) begin
                if (v[i]) stop = 1;
                if (!stop) n++;
            end
            2'b01: for (int i = 0; i < 32; i++) begin
                if (v[i]) stop = 1;
                if (!stop) n++;
            end
            2'b10: for (int i = 0; i < 32; i++) n += int'(v[i]);
            default: n = 0;
        endcase
        return 32'(n);
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] v);
        if (op == 2'b11) return 1;
`ifdef ZBB_COUNT_EARLY_EXIT_EN
        if (op != 2'b10 && v != 0) begin
            for (int k = 0; k < 8; k++) begin
                logic [3:0] nib;
                nib = (op == 2'b00) ? v[31 - 4*k -: 4] : v[4*k +: 4];
                if (nib != 0) return k + 2;
            end
        end
`endif
        return 9;
    endfunction

    // ---------------- driver tasks ----------------
    // Presents a request in the current cycle T; returns at the negedge of T+1.
    task automatic issue(input logic [1:0] o, input logic [31:0] v);
        bus.start   = 1'b1;
        bus.op      = o;
        bus.operand = v;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    // Waits (bounded) for done; n = cycles after T at which done is seen.
    task automatic wait_done(output int n, output bit stable, output bit excl);
        logic [31:0] old_res;
        n = 1;
        stable = 1;
        excl = 1;
        old_res = bus.result;
        while (!bus.done && n < 20) begin
            if (bus.result !== old_res) stable = 0;
            if (bus.busy && bus.done) excl = 0;
            @(negedge clk);
            n++;
        end
        if (bus.busy && bus.done) excl = 0;
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] v,
                          input logic [31:0] exp_res, input int exp_lat);
        int n;
        bit stable, excl;
        exp_q.push_back(exp_res);
        issue(o, v);
        wait_done(n, stable, excl);
        check({name, "_lat"}, 32'(n), 32'(exp_lat));
        check({name, "_res"}, bus.result, exp_q.pop_front());
        check({name, "_excl"}, 32'(excl), 32'd1);
        if (exp_lat > 1) check({name, "_stable_in_run"}, 32'(stable), 32'd1);
    endtask

    // ---------------- test ----------------
    initial begin
        int n;
        bit stable, excl, seen_done;
        int exp_lat;

        tbl[0]  = '{2'b10, 32'hB92F04A1, 32'h0000000E, 9, 9};
        tbl[1]  = '{2'b00, 32'h40AC8810, 32'h00000001, 9, 2};
        tbl[2]  = '{2'b01, 32'h40AC8810, 32'h00000004, 9, 3};
        tbl[3]  = '{2'b00, 32'h00000000, 32'h00000020, 9, 9};
        tbl[4]  = '{2'b01, 32'h00000000, 32'h00000020, 9, 9};
        tbl[5]  = '{2'b10, 32'hFFFFFFFF, 32'h00000020, 9, 9};
        tbl[6]  = '{2'b10, 32'h00000000, 32'h00000000, 9, 9};
        tbl[7]  = '{2'b11, 32'hDEADBEEF, 32'h00000000, 1, 1};
        tbl[8]  = '{2'b00, 32'h80000000, 32'h00000000, 9, 2};
        tbl[9]  = '{2'b01, 32'h00000001, 32'h00000000, 9, 2};
        tbl[10] = '{2'b00, 32'h00000001, 32'h0000001F, 9, 9};
        tbl[11] = '{2'b01, 32'h80000000, 32'h0000001F, 9, 9};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.operand = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // ---- table-driven vectors ----
        for (int i = 0; i < 12; i++) begin
`ifdef ZBB_COUNT_EARLY_EXIT_EN
            exp_lat = tbl[i].lat_ee;
`else
            exp_lat = tbl[i].lat_fixed;
`endif
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].operand, tbl[i].res, exp_lat);
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), 32'(bus.done), 32'd0);
        end

        // ---- start in RUN is ignored ----
        exp_q.push_back(32'd4);
        issue(ZBB_CNT_CPOP, 32'h0000000F);
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.op = ZBB_CNT_CTZ; bus.operand = 32'h00000000;
        @(negedge clk);
        bus.start = 1'b0;
        n = 4;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ignore_lat", 32'(n), 32'd9);
        check("ignore_res", bus.result, exp_q.pop_front());
        @(negedge clk);
        check("ignore_no_restart_busy", 32'(bus.busy), 32'd0);
        check("ignore_no_restart_done", 32'(bus.done), 32'd0);

        // ---- back-to-back: start held in DONE ----
        run_op("b2b_first", ZBB_CNT_CPOP, 32'hB92F04A1, 32'h0000000E, 9);
        exp_q.push_back(32'd4);
        issue(ZBB_CNT_CTZ, 32'h40AC8810);
        check("b2b_no_idle_busy", 32'(bus.busy), 32'd1);
        wait_done(n, stable, excl);
`ifdef ZBB_COUNT_EARLY_EXIT_EN
        check("b2b_second_lat", 32'(n), 32'd3);
`else
        check("b2b_second_lat", 32'(n), 32'd9);
`endif
        check("b2b_second_res", bus.result, exp_q.pop_front());
        @(negedge clk);

        // ---- reset in RUN cycle 4 ----
        issue(ZBB_CNT_CPOP, 32'hFFFFFFFF);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_run_busy", 32'(bus.busy), 32'd0);
        check("rst_run_done", 32'(bus.done), 32'd0);
        check("rst_run_result", bus.result, 32'd0);
        check("rst_run_state", 32'(dbg_state), 32'(ST_IDLE));
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_done = 1;
        end
        check("rst_run_no_done", 32'(seen_done), 32'd0);

        // ---- rst has priority over start ----
        bus.start = 1'b1; bus.op = ZBB_CNT_CPOP; bus.operand = 32'h1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        check("rst_prio_busy", 32'(bus.busy), 32'd0);
        check("rst_prio_state", 32'(dbg_state), 32'(ST_IDLE));

        // ---- randomized stimulus vs reference model ----
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [31:0] v;
            o = 2'($urandom_range(0, 3));
            v = $urandom;
            case ($urandom_range(0, 3))
                0: v = v & (32'hFFFFFFFF >> (4 * $urandom_range(0, 8)));
                1: v = v << (4 * $urandom_range(0, 7));
                2: v = 32'h0;
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), o, v, ref_count(o, v), ref_lat(o, v));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zbb_count_ctrl.md
ZBB_COUNT_CTRL -- requirements
Module: zbb_count_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: start  input  1  request; sampled when busy=0.
REQ-004 SHALL have port: op  input  2  00=clz, 01=ctz, 10=cpop, 11=reserved; sampled with start.
REQ-005 SHALL have port: operand  input  32  source (rs1 value); sampled with start.
REQ-006 SHALL have port: busy  output  1  high in RUN; CPU stall qualifier.
REQ-007 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-008 SHALL have port: result  output  32  count, zero-extended from 6 bits.

Function
REQ-009 SHALL implement FSM states IDLE, RUN, DONE.
REQ-010 SHALL, in IDLE or DONE with start=1 and op!=11, load operand into a 32-bit shift register, clear the accumulator and the found flag, set the nibble counter to 0, and go to RUN.
REQ-011 SHALL, with start=1 and op=11, go directly to DONE with result=0 (done at T+1).
REQ-012 SHALL, in RUN, examine one nibble per cycle: clz from MSB (shift left 4), ctz/cpop from LSB (shift right 4).
REQ-013 SHALL, for cpop, add the popcount of the nibble (0..4) to the accumulator.
REQ-014 SHALL, for clz/ctz with found=0: add 4 if the nibble is zero; otherwise add the nibble's leading (clz) or trailing (ctz) zero count (0..3) and set found=1.
REQ-015 SHALL, for clz/ctz with found=1, leave the accumulator unchanged.
REQ-016 SHALL leave RUN for DONE after the 8th nibble (counter 7->DONE); without early exit, latency is fixed: start at cycle T -> done high in cycle T+9.
REQ-017 SHALL keep the accumulator within 6 bits (max 32); operand 0 gives clz=ctz=32 and cpop=0.
REQ-018 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE unless start=1 (back-to-back accepted).
REQ-019 SHALL hold result stable from DONE until the next accepted start; result SHALL NOT change in RUN.
REQ-020 SHALL ignore start while in RUN (no queueing, no effect on the current operation).
REQ-021 SHALL assert busy exactly in RUN; done and busy SHALL never both be high.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, force IDLE, busy=0, done=0, result=0, and clear the accumulator, counter and found flag.
REQ-023 SHALL, on reset during RUN, abort the operation with no done pulse; rst SHALL take priority over start.

Configuration
REQ-024 SHALL support macro ZBB_COUNT_EARLY_EXIT_EN.
REQ-025 SHALL, with the macro defined, move clz/ctz from RUN to DONE in the cycle found is set (latency T+1+k+1, where k is the number of nibbles before the nonzero one); cpop and zero operands still take 8 RUN cycles.
REQ-026 SHALL, without the macro, use the fixed latency of REQ-016 for all ops.

Structure
REQ-027 SHALL take from shared package zbb_pkg: op encodings (ZBB_CNT_CLZ/CTZ/CPOP), FSM state typedef, NIBBLES=8, CNT_W=6.
REQ-028 SHALL instantiate sub-module zbb_nibble_cnt (combinational: 4-bit in -> lz, tz, pop each 3 bits).

Verification
REQ-029 SHALL cover: cpop, operand 0xB92F04A1 -> result 0x0000000E, done at T+9 in both configs.
REQ-030 SHALL cover: clz, operand 0x40AC8810 -> result 0x00000001; done at T+2 with the macro, T+9 without.
REQ-031 SHALL cover: ctz, operand 0x40AC8810 -> result 0x00000004; done at T+3 with the macro, T+9 without.
REQ-032 SHALL cover: clz and ctz, operand 0x00000000 -> result 0x00000020 at T+9; cpop of 0xFFFFFFFF -> 0x00000020.
REQ-033 SHALL cover: start asserted in RUN with a different operand -> ignored, first result unchanged; start held in DONE -> second operation starts with no IDLE cycle.
REQ-034 SHALL cover: rst pulsed in RUN cycle 4 -> IDLE next cycle, busy=0, result=0, no done pulse; op=11 -> done at T+1 with result 0.
